control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 63 ++++++
 rtl/cu_decode.sv | 65 ++++++
 rtl/control_unit.sv | 77 +++++++
 tb/tb_control_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: opcodes, FSM state codes, accumulator
// source selects and the bundle of datapath control strobes.
package cu_pkg;

   // Opcode field values as seen in IR[2:0]
   localparam logic [2:0] OpLoad  = 3'b000;
   localparam logic [2:0] OpStore = 3'b001;
   localparam logic [2:0] OpAdd   = 3'b010;
   localparam logic [2:0] OpSub   = 3'b011;
   localparam logic [2:0] OpInput = 3'b100;
   localparam logic [2:0] OpJz    = 3'b101;
   localparam logic [2:0] OpJpos  = 3'b110;
   localparam logic [2:0] OpHalt  = 3'b111;

   // Accumulator source selects
   localparam logic [1:0] AselAlu = 2'b00;
   localparam logic [1:0] AselIn  = 2'b01;
   localparam logic [1:0] AselRam = 2'b10;

   // 4-bit state codes, exported on the State debug port
   typedef enum logic [3:0] {
      StStart  = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StLoad   = 4'd3,
      StStore  = 4'd4,
      StAdd    = 4'd5,
      StSub    = 4'd6,
      StInput  = 4'd7,
      StInwait = 4'd8,
      StJz     = 4'd9,
      StJpos   = 4'd10,
      StHalt   = 4'd11
   } state_t;

   // Datapath control strobes produced by the decoder
   typedef struct packed {
      logic       irload;
      logic       pcload;
      logic       jmpmux;
      logic       meminst;
      logic       memwr;
      logic       aload;
      logic       sub;
      logic [1:0] asel;
      logic       halt;
   } ctrl_t;

   // Execute state selected by an opcode in DECODE
   function automatic state_t op_to_state(input logic [2:0] op);
      case (op)
         OpLoad:  return StLoad;
         OpStore: return StStore;
         OpAdd:   return StAdd;
         OpSub:   return StSub;
         OpInput: return StInput;
         OpJz:    return StJz;
         OpJpos:  return StJpos;
         default: return StHalt;
      endcase
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational map from the current state (plus Enter and the accumulator
// flags for the Mealy strobes) to the datapath control strobes.
module cu_decode
   import cu_pkg::*;
(
   input  state_t i_state,
   input  logic   i_enter,
   input  logic   i_aeq0,
   input  logic   i_apos,
   output ctrl_t  o_ctrl
);

   // Decode strobes; everything defaults low so START, INWAIT and unused codes emit nothing
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         StFetch: begin
            // JMPmux stays 0 so the PC increments
            o_ctrl.irload = 1'b1;
            o_ctrl.pcload = 1'b1;
         end
         StDecode: begin
            o_ctrl.meminst = 1'b1;
         end
         StLoad: begin
            o_ctrl.meminst = 1'b1;
            o_ctrl.asel    = AselRam;
            o_ctrl.aload   = 1'b1;
         end
         StStore: begin
            o_ctrl.meminst = 1'b1;
            o_ctrl.memwr   = 1'b1;
         end
         StAdd: begin
            o_ctrl.meminst = 1'b1;
            o_ctrl.asel    = AselAlu;
            o_ctrl.aload   = 1'b1;
         end
         StSub: begin
            o_ctrl.meminst = 1'b1;
            o_ctrl.asel    = AselAlu;
            o_ctrl.aload   = 1'b1;
            o_ctrl.sub     = 1'b1;
         end
         StInput: begin
            // Accumulator captures data_in during the cycle the operator strobes Enter
            o_ctrl.asel  = AselIn;
            o_ctrl.aload = i_enter;
         end
         StJz: begin
            o_ctrl.jmpmux = 1'b1;
            o_ctrl.pcload = i_aeq0;
         end
         StJpos: begin
            o_ctrl.jmpmux = 1'b1;
            o_ctrl.pcload = i_apos;
         end
         StHalt: begin
            o_ctrl.halt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Control unit FSM for the simple accumulator CPU: fetch, decode and execute
// sequencing, with operator-paced input and a sticky halt.
module control_unit
   import cu_pkg::*;
#(
   parameter int unsigned ENTER_RELEASE = 1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enter,
   input  logic [2:0] IR,
   input  logic       Aeq0,
   input  logic       Apos,
   output logic       IRload,
   output logic       PCload,
   output logic       JMPmux,
   output logic       Meminst,
   output logic       MemWr,
   output logic       Aload,
   output logic       Sub,
   output logic [1:0] Asel,
   output logic       Halt,
   output logic [3:0] State
);

   state_t r_state;
   ctrl_t  w_ctrl;

   // State register and transitions; Enter only matters in INPUT and INWAIT
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= StStart;
      end else begin
         case (r_state)
            StStart:  r_state <= StFetch;
            StFetch:  r_state <= StDecode;
            StDecode: r_state <= op_to_state(IR);
            StLoad, StStore, StAdd, StSub, StJz, StJpos: begin
               r_state <= StFetch;
            end
            StInput: begin
               if (Enter) begin
                  r_state <= (ENTER_RELEASE != 0) ? StInwait : StFetch;
               end
            end
            StInwait: begin
               if (!Enter) begin
                  r_state <= StFetch;
               end
            end
            StHalt:   r_state <= StHalt;
            default:  r_state <= StStart;
         endcase
      end
   end

   // Strobes decode straight from the state register so reset clears them asynchronously
   cu_decode u_decode (
      .i_state (r_state),
      .i_enter (Enter),
      .i_aeq0  (Aeq0),
      .i_apos  (Apos),
      .o_ctrl  (w_ctrl)
   );

   assign IRload  = w_ctrl.irload;
   assign PCload  = w_ctrl.pcload;
   assign JMPmux  = w_ctrl.jmpmux;
   assign Meminst = w_ctrl.meminst;
   assign MemWr   = w_ctrl.memwr;
   assign Aload   = w_ctrl.aload;
   assign Sub     = w_ctrl.sub;
   assign Asel    = w_ctrl.asel;
   assign Halt    = w_ctrl.halt;
   assign State   = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-scenario tasks push stimulus plus expected
// outputs into a queue, then pop them cycle by cycle and compare.
module tb_control_unit;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       enter_tb = 1'b0;
   logic [2:0] ir_tb = 3'b000;
   logic       aeq0_tb = 1'b0;
   logic       apos_tb = 1'b0;
   logic       dp_en = 1'b0;

   logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
   logic [1:0] Asel;
   logic [3:0] State;
   logic [2:0] w_ir;
   logic       w_aeq0, w_apos;

   // Small datapath model used for the program run
   logic [7:0] ram [32];
   logic [4:0] dp_pc;
   logic [7:0] dp_ir;
   logic [7:0] dp_a;
   logic [4:0] w_addr;

   int n_checks = 0;
   int n_errors = 0;

   // Expected observation: {State, IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Halt}
   localparam logic [13:0] E_START  = {4'd0,  7'b0000000, 2'b00, 1'b0};
   localparam logic [13:0] E_FETCH  = {4'd1,  7'b1100000, 2'b00, 1'b0};
   localparam logic [13:0] E_DECODE = {4'd2,  7'b0001000, 2'b00, 1'b0};
   localparam logic [13:0] E_LOAD   = {4'd3,  7'b0001010, 2'b10, 1'b0};
   localparam logic [13:0] E_STORE  = {4'd4,  7'b0001100, 2'b00, 1'b0};
   localparam logic [13:0] E_ADD    = {4'd5,  7'b0001010, 2'b00, 1'b0};
   localparam logic [13:0] E_SUB    = {4'd6,  7'b0001011, 2'b00, 1'b0};
   localparam logic [13:0] E_IN0    = {4'd7,  7'b0000000, 2'b01, 1'b0};
   localparam logic [13:0] E_IN1    = {4'd7,  7'b0000010, 2'b01, 1'b0};
   localparam logic [13:0] E_INWAIT = {4'd8,  7'b0000000, 2'b00, 1'b0};
   localparam logic [13:0] E_JZ1    = {4'd9,  7'b0110000, 2'b00, 1'b0};
   localparam logic [13:0] E_JZ0    = {4'd9,  7'b0010000, 2'b00, 1'b0};
   localparam logic [13:0] E_JP1    = {4'd10, 7'b0110000, 2'b00, 1'b0};
   localparam logic [13:0] E_JP0    = {4'd10, 7'b0010000, 2'b00, 1'b0};
   localparam logic [13:0] E_HALT   = {4'd11, 7'b0000000, 2'b00, 1'b1};

   typedef struct packed {
      logic        enter;
      logic [2:0]  ir;
      logic        aeq0;
      logic        apos;
      logic [13:0] exp;
   } item_t;

   item_t sb[$];

   assign w_ir   = dp_en ? dp_ir[7:5] : ir_tb;
   assign w_aeq0 = dp_en ? (dp_a == 8'd0) : aeq0_tb;
   assign w_apos = dp_en ? ~dp_a[7] : apos_tb;
   assign w_addr = Meminst ? dp_ir[4:0] : dp_pc;

   control_unit #(.ENTER_RELEASE(1)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Enter   (enter_tb),
      .IR      (w_ir),
      .Aeq0    (w_aeq0),
      .Apos    (w_apos),
      .IRload  (IRload),
      .PCload  (PCload),
      .JMPmux  (JMPmux),
      .Meminst (Meminst),
      .MemWr   (MemWr),
      .Aload   (Aload),
      .Sub     (Sub),
      .Asel    (Asel),
      .Halt    (Halt),
      .State   (State)
   );

   always #5 Clock = ~Clock;

   // Datapath: reset reloads the program LOAD 10, ADD 11, STORE 12, HALT
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) ram[i] <= 8'd0;
         ram[0]  <= {3'b000, 5'd10};
         ram[1]  <= {3'b010, 5'd11};
         ram[2]  <= {3'b001, 5'd12};
         ram[3]  <= {3'b111, 5'd0};
         ram[10] <= 8'd5;
         ram[11] <= 8'd3;
         dp_pc   <= 5'd0;
         dp_ir   <= 8'd0;
         dp_a    <= 8'd0;
      end else begin
         if (IRload) dp_ir <= ram[dp_pc];
         if (PCload) dp_pc <= JMPmux ? dp_ir[4:0] : dp_pc + 5'd1;
         if (MemWr) ram[w_addr] <= dp_a;
         if (Aload) begin
            case (Asel)
               2'b00:   dp_a <= Sub ? dp_a - ram[w_addr] : dp_a + ram[w_addr];
               2'b01:   dp_a <= 8'd0;
               2'b10:   dp_a <= ram[w_addr];
               default: dp_a <= dp_a;
            endcase
         end
      end
   end

   function automatic logic [13:0] obs();
      return {State, IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Halt};
   endfunction

   task automatic push(input logic en, input logic [2:0] ir, input logic z, input logic p,
                       input logic [13:0] exp);
      item_t it;
      it.enter = en;
      it.ir    = ir;
      it.aeq0  = z;
      it.apos  = p;
      it.exp   = exp;
      sb.push_back(it);
   endtask

   // Leaves the bench at posedge+1 with Reset low and the DUT in START
   task automatic apply_reset();
      @(posedge Clock);
      #1 Reset = 1'b1;
      #2;
      @(posedge Clock);
      #1 Reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (obs() !== E_START) begin
         n_errors++;
         $display("FAIL reset_hold: got %h expected %h", obs(), E_START);
      end
   endtask

   task automatic test_load();
      item_t it;
      int    k = 0;
      apply_reset();
      push(0, 3'b000, 0, 0, E_START);
      push(0, 3'b000, 0, 0, E_FETCH);
      push(0, 3'b000, 0, 0, E_DECODE);
      push(0, 3'b000, 0, 0, E_LOAD);
      push(0, 3'b000, 0, 0, E_FETCH);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         enter_tb = it.enter; ir_tb = it.ir; aeq0_tb = it.aeq0; apos_tb = it.apos;
         #2;
         n_checks++;
         if (obs() !== it.exp) begin
            n_errors++;
            $display("FAIL load[%0d]: got %h expected %h", k, obs(), it.exp);
         end
         k++;
         if (sb.size() > 0) begin @(posedge Clock); #1; end
      end
   endtask

   task automatic test_jumps();
      item_t it;
      int    k = 0;
      apply_reset();
      push(0, 3'b101, 1, 0, E_START);
      push(0, 3'b101, 1, 0, E_FETCH);
      push(0, 3'b101, 1, 0, E_DECODE);
      push(0, 3'b101, 1, 0, E_JZ1);
      push(0, 3'b101, 0, 1, E_FETCH);
      push(0, 3'b101, 0, 1, E_DECODE);
      push(0, 3'b101, 0, 1, E_JZ0);
      push(0, 3'b110, 0, 1, E_FETCH);
      push(0, 3'b110, 0, 1, E_DECODE);
      push(0, 3'b110, 1, 1, E_JP1);
      push(0, 3'b110, 1, 0, E_FETCH);
      push(0, 3'b110, 1, 0, E_DECODE);
      push(0, 3'b110, 1, 0, E_JP0);
      push(0, 3'b011, 0, 0, E_FETCH);
      push(0, 3'b011, 0, 0, E_DECODE);
      push(0, 3'b011, 0, 0, E_SUB);
      push(0, 3'b010, 0, 0, E_FETCH);
      push(0, 3'b010, 0, 0, E_DECODE);
      push(0, 3'b010, 0, 0, E_ADD);
      push(0, 3'b010, 0, 0, E_FETCH);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         enter_tb = it.enter; ir_tb = it.ir; aeq0_tb = it.aeq0; apos_tb = it.apos;
         #2;
         n_checks++;
         if (obs() !== it.exp) begin
            n_errors++;
            $display("FAIL jumps[%0d]: got %h expected %h", k, obs(), it.exp);
         end
         k++;
         if (sb.size() > 0) begin @(posedge Clock); #1; end
      end
   endtask

   task automatic test_input();
      item_t it;
      int    k = 0;
      int    aload_cnt = 0;
      apply_reset();
      push(1, 3'b100, 0, 0, E_START);
      push(1, 3'b100, 0, 0, E_FETCH);
      push(1, 3'b100, 0, 0, E_DECODE);
      for (int i = 0; i < 5; i++) push(0, 3'b100, 0, 0, E_IN0);
      push(1, 3'b100, 0, 0, E_IN1);
      push(1, 3'b100, 0, 0, E_INWAIT);
      push(1, 3'b100, 0, 0, E_INWAIT);
      push(0, 3'b100, 0, 0, E_INWAIT);
      push(0, 3'b100, 0, 0, E_FETCH);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         enter_tb = it.enter; ir_tb = it.ir; aeq0_tb = it.aeq0; apos_tb = it.apos;
         #2;
         if (Aload === 1'b1) aload_cnt++;
         n_checks++;
         if (obs() !== it.exp) begin
            n_errors++;
            $display("FAIL input[%0d]: got %h expected %h", k, obs(), it.exp);
         end
         k++;
         if (sb.size() > 0) begin @(posedge Clock); #1; end
      end
      enter_tb = 1'b0;
      n_checks++;
      if (aload_cnt != 1) begin
         n_errors++;
         $display("FAIL input_aload_count: got %0d expected 1", aload_cnt);
      end
   endtask

   task automatic test_halt();
      item_t it;
      int    k = 0;
      apply_reset();
      push(0, 3'b111, 0, 0, E_START);
      push(0, 3'b111, 0, 0, E_FETCH);
      push(0, 3'b111, 0, 0, E_DECODE);
      for (int i = 0; i < 20; i++) begin
         push(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), E_HALT);
      end
      while (sb.size() > 0) begin
         it = sb.pop_front();
         enter_tb = it.enter; ir_tb = it.ir; aeq0_tb = it.aeq0; apos_tb = it.apos;
         #2;
         n_checks++;
         if (obs() !== it.exp) begin
            n_errors++;
            $display("FAIL halt[%0d]: got %h expected %h", k, obs(), it.exp);
         end
         k++;
         if (sb.size() > 0) begin @(posedge Clock); #1; end
      end
      enter_tb = 1'b0;
      #1 Reset = 1'b1;
      #1;
      n_checks++;
      if (obs() !== E_START) begin
         n_errors++;
         $display("FAIL halt_reset: got %h expected %h", obs(), E_START);
      end
   endtask

   task automatic test_store_reset();
      item_t it;
      int    k = 0;
      apply_reset();
      push(0, 3'b001, 0, 0, E_START);
      push(0, 3'b001, 0, 0, E_FETCH);
      push(0, 3'b001, 0, 0, E_DECODE);
      push(0, 3'b001, 0, 0, E_STORE);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         enter_tb = it.enter; ir_tb = it.ir; aeq0_tb = it.aeq0; apos_tb = it.apos;
         #2;
         n_checks++;
         if (obs() !== it.exp) begin
            n_errors++;
            $display("FAIL store[%0d]: got %h expected %h", k, obs(), it.exp);
         end
         k++;
         if (sb.size() > 0) begin @(posedge Clock); #1; end
      end
      // Still between edges in STORE: reset must kill MemWr without a clock
      #1 Reset = 1'b1;
      #1;
      n_checks++;
      if (MemWr !== 1'b0 || obs() !== E_START) begin
         n_errors++;
         $display("FAIL store_mid_reset: got MemWr=%b obs=%h expected MemWr=0 obs=%h",
                  MemWr, obs(), E_START);
      end
      @(posedge Clock);
      #1 Reset = 1'b0;
      #2;
      n_checks++;
      if (obs() !== E_START) begin
         n_errors++;
         $display("FAIL store_after_release: got %h expected %h", obs(), E_START);
      end
      @(posedge Clock);
      #3;
      n_checks++;
      if (obs() !== E_FETCH) begin
         n_errors++;
         $display("FAIL store_first_fetch: got %h expected %h", obs(), E_FETCH);
      end
   endtask

   task automatic test_program();
      int cyc = 0;
      dp_en = 1'b1;
      enter_tb = 1'b0;
      apply_reset();
      while (Halt !== 1'b1 && cyc < 40) begin
         @(posedge Clock);
         #1;
         cyc++;
      end
      // START + 3 instructions x 3 cycles + FETCH, DECODE of HALT
      n_checks++;
      if (cyc != 12) begin
         n_errors++;
         $display("FAIL prog_halt_cycle: got %0d expected 12", cyc);
      end
      n_checks++;
      if (ram[12] !== 8'd8) begin
         n_errors++;
         $display("FAIL prog_ram12: got %0d expected 8", ram[12]);
      end
      n_checks++;
      if (dp_a !== 8'd8) begin
         n_errors++;
         $display("FAIL prog_acc: got %0d expected 8", dp_a);
      end
      dp_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_jumps();
      test_input();
      test_halt();
      test_store_reset();
      test_program();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
